jt51_wrseq: RTL and testbench

Host-side write sequencer for the JT51 CPU port. It buffers (register address, data) commands in a small FIFO and replays each one as an address write (a0=0) followed by a data write (a0=1) on the chip's write/a0/din interface. It waits for the chip's busy flag before starting each command and skips redundant address writes. It sits between a system bus/CPU shim and the jt51 top, so software never has to poll busy.

---
 rtl/jt51_wrseq.sv | 147 ++++++++++++++
 tb/tb_jt51_wrseq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_wrseq.sv
// jt51_wrseq: host-side write sequencer for the JT51 CPU port.
// Queues (register, value) commands and replays each one as an address write
// followed by a data write. It waits for the chip's busy flag before each
// command and optionally skips an address write that would repeat the last one.
module jt51_wrseq #(
  parameter int DEPTH_LOG2 = 3,
  parameter int BUSY_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [7:0]            cmd_addr,
  input  logic [7:0]            cmd_data,
  input  logic                  addr_cache_en,
  output logic                  wr_write,
  output logic                  wr_a0,
  output logic [7:0]            wr_din,
  input  logic                  wr_busy,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  idle
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (BUSY_LAT > 1) ? $clog2(BUSY_LAT) : 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [CNT_W-1:0]      HOLD_ONE = 1;
  localparam logic [CNT_W-1:0]      HOLD_LD  = CNT_W'(BUSY_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_GAP, S_DATA, S_HOLD, S_WAITB
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      hold_q, hold_d;
  logic [7:0]            last_addr_q, last_addr_d;
  logic                  last_valid_q, last_valid_d;
  logic                  wr_write_q, wr_write_d;
  logic                  wr_a0_q, wr_a0_d;
  logic [7:0]            wr_din_q, wr_din_d;
  logic [15:0]           mem_q [DEPTH];

  logic [15:0] head;
  logic        push, pop, hit;

  assign head      = mem_q[rd_ptr_q];
  assign cmd_ready = (cnt_q != LVL_FULL);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_d == S_DATA);
  assign hit       = addr_cache_en & last_valid_q & (head[15:8] == last_addr_q);
  assign level     = cnt_q;
  assign idle      = (state_q == S_IDLE) && (cnt_q == '0);
  assign wr_write  = wr_write_q;
  assign wr_a0     = wr_a0_q;
  assign wr_din    = wr_din_q;

  // Command storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_addr, cmd_data};
  end

  // FIFO pointers and occupancy; a pop only happens while a command is queued.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      cnt_d = cnt_q + LVL_ONE;
    else if (!push && pop) cnt_d = cnt_q - LVL_ONE;
  end

  // Next state plus registered Moore decode of the outputs from that next state.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    last_addr_d  = last_addr_q;
    last_valid_d = last_valid_q;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0 && !wr_busy) state_d = hit ? S_DATA : S_ADDR;
      end
      S_ADDR: begin
        state_d      = S_GAP;
        last_addr_d  = head[15:8];
        last_valid_d = 1'b1;
      end
      S_GAP: state_d = S_DATA;
      S_DATA: begin
        state_d = S_HOLD;
        hold_d  = HOLD_LD;
      end
      S_HOLD: begin
        if (hold_q == '0) state_d = S_WAITB;
        else              hold_d  = hold_q - HOLD_ONE;
      end
      S_WAITB: begin
        if (!wr_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_write_d = (state_d == S_ADDR) || (state_d == S_DATA);
    wr_a0_d    = wr_a0_q;
    wr_din_d   = wr_din_q;
    if (state_d == S_ADDR) begin
      wr_a0_d  = 1'b0;
      wr_din_d = head[15:8];
    end else if (state_d == S_DATA) begin
      wr_a0_d  = 1'b1;
      wr_din_d = head[7:0];
    end
  end

  // Control and output registers; reset cuts any strobe and drops the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      hold_q       <= '0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
      wr_write_q   <= 1'b0;
      wr_a0_q      <= 1'b0;
      wr_din_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      hold_q       <= hold_d;
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
      wr_write_q   <= wr_write_d;
      wr_a0_q      <= wr_a0_d;
      wr_din_q     <= wr_din_d;
    end
  end

endmodule

// File: tb/tb_jt51_wrseq.sv
// Directed bench for jt51_wrseq with a strobe recorder and a simple busy model.
module tb_jt51_wrseq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       addr_cache_en = 1'b0;
  logic       wr_write, wr_a0;
  logic [7:0] wr_din;
  logic       wr_busy;
  logic [3:0] level;
  logic       idle;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bcnt = 0;
  logic busy_man = 1'b0;
  logic chip_en = 1'b0;
  logic prev_wr = 1'b0;
  logic prev_busy = 1'b0;
  int idle_cyc = 0;
  int c1 = 0;

  typedef struct {
    int         cyc;
    logic       a0;
    logic [7:0] din;
  } strobe_t;
  strobe_t strobes[$];
  int busy_fall[$];

  jt51_wrseq #(.DEPTH_LOG2(3), .BUSY_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .addr_cache_en(addr_cache_en),
    .wr_write(wr_write), .wr_a0(wr_a0), .wr_din(wr_din), .wr_busy(wr_busy),
    .level(level), .idle(idle)
  );

  always #5 clk = ~clk;

  assign wr_busy = busy_man | (chip_en && bcnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Chip busy model: busy from the cycle after a data strobe, for 64 cycles.
  always @(posedge clk) begin
    if (chip_en && wr_write && wr_a0) bcnt <= 64;
    else if (bcnt != 0)               bcnt <= bcnt - 1;
  end

  // Strobe recorder and back-to-back strobe guard.
  always @(negedge clk) begin
    if (wr_write) begin
      chk("no_consecutive_strobe", {31'b0, prev_wr}, 0);
      strobes.push_back('{cyc: cyc, a0: wr_a0, din: wr_din});
    end
    if (prev_busy && !wr_busy) busy_fall.push_back(cyc);
    prev_wr   = wr_write;
    prev_busy = wr_busy;
  end

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("push_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!idle && n < bound) begin @(negedge clk); n++; end
    if (!idle) chk("idle_timeout", 0, 1);
    idle_cyc = cyc;
  endtask

  task automatic wait_strobe(input int bound);
    int n = 0;
    while (!wr_write && n < bound) begin @(negedge clk); n++; end
    if (!wr_write) chk("strobe_timeout", 0, 1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, cmd_ready}, 1);
    chk("rst_idle", {31'b0, idle}, 1);
    chk("rst_level", {28'b0, level}, 0);
    chk("rst_write", {31'b0, wr_write}, 0);
    chk("rst_a0", {31'b0, wr_a0}, 0);
    chk("rst_din", {24'b0, wr_din}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single command, cache off
    push(8'h14, 8'h15);
    c1 = cyc;
    chk("t1_idle_low", {31'b0, idle}, 0);
    chk("t1_level1", {28'b0, level}, 1);
    wait_idle(50);
    chk("t1_count", strobes.size(), 2);
    if (strobes.size() == 2) begin
      chk("t1_a_latency", strobes[0].cyc - c1, 1);
      chk("t1_a_a0", {31'b0, strobes[0].a0}, 0);
      chk("t1_a_din", {24'b0, strobes[0].din}, 32'h14);
      chk("t1_d_a0", {31'b0, strobes[1].a0}, 1);
      chk("t1_d_din", {24'b0, strobes[1].din}, 32'h15);
      chk("t1_gap", strobes[1].cyc - strobes[0].cyc, 2);
      chk("t1_idle_delay", idle_cyc - strobes[1].cyc, 4);
    end
    chk("t1_level0", {28'b0, level}, 0);
    strobes.delete();

    // Address cache on: second command to same register is data-only
    addr_cache_en = 1'b1;
    push(8'h28, 8'h4A);
    push(8'h28, 8'h4B);
    wait_idle(100);
    chk("t2_hit_count", strobes.size(), 3);
    if (strobes.size() == 3) begin
      chk("t2_a_din", {23'b0, strobes[0].a0, strobes[0].din}, 32'h028);
      chk("t2_d1", {23'b0, strobes[1].a0, strobes[1].din}, 32'h14A);
      chk("t2_d2", {23'b0, strobes[2].a0, strobes[2].din}, 32'h14B);
      chk("t2_hit_period", strobes[2].cyc - strobes[1].cyc, 5);
    end
    strobes.delete();
    addr_cache_en = 1'b0;
    push(8'h28, 8'h4C);
    push(8'h28, 8'h4D);
    wait_idle(100);
    chk("t2_miss_count", strobes.size(), 4);
    if (strobes.size() == 4) begin
      chk("t2m_a1", {23'b0, strobes[0].a0, strobes[0].din}, 32'h028);
      chk("t2m_d1", {23'b0, strobes[1].a0, strobes[1].din}, 32'h14C);
      chk("t2m_a2", {23'b0, strobes[2].a0, strobes[2].din}, 32'h028);
      chk("t2m_d2", {23'b0, strobes[3].a0, strobes[3].din}, 32'h14D);
      chk("t2_miss_period", strobes[3].cyc - strobes[1].cyc, 7);
    end
    strobes.delete();

    // Fill with busy held high, then release
    busy_man = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i), 8'h80 + 8'(i));
    cmd_valid = 1'b1; cmd_addr = 8'h38; cmd_data = 8'h88;
    repeat (3) @(negedge clk);
    chk("t3_ready_low", {31'b0, cmd_ready}, 0);
    chk("t3_level_full", {28'b0, level}, 8);
    chk("t3_no_strobes", strobes.size(), 0);
    busy_man = 1'b0;
    begin
      int n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      chk("t3_retry_ready", {31'b0, cmd_ready}, 1);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle(500);
    chk("t3_count", strobes.size(), 18);
    if (strobes.size() == 18) begin
      for (int i = 0; i < 9; i++) begin
        chk("t3_addr", {23'b0, strobes[2*i].a0, strobes[2*i].din}, 32'h030 + i);
        chk("t3_data", {23'b0, strobes[2*i+1].a0, strobes[2*i+1].din}, 32'h180 + i);
      end
    end
    strobes.delete();

    // Chip busy model: next command waits for busy to fall
    busy_fall.delete();
    chip_en = 1'b1;
    push(8'h40, 8'h01);
    push(8'h41, 8'h02);
    wait_idle(400);
    chk("t4_count", strobes.size(), 4);
    chk("t4_fall_seen", {31'b0, busy_fall.size() != 0}, 1);
    if (strobes.size() == 4 && busy_fall.size() != 0) begin
      chk("t4_after_fall", {31'b0, strobes[2].cyc > busy_fall[0]}, 1);
      chk("t4_period", strobes[2].cyc - strobes[1].cyc, 67);
      chk("t4_a2", {23'b0, strobes[2].a0, strobes[2].din}, 32'h041);
      chk("t4_d2", {23'b0, strobes[3].a0, strobes[3].din}, 32'h102);
    end
    chip_en = 1'b0;
    strobes.delete();

    // Reset during GAP
    addr_cache_en = 1'b1;
    push(8'h50, 8'h11);
    wait_strobe(20);
    @(negedge clk);
    chk("t5_gap_level", {28'b0, level}, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_write", {31'b0, wr_write}, 0);
    chk("t5_level", {28'b0, level}, 0);
    chk("t5_idle", {31'b0, idle}, 1);
    chk("t5_din", {24'b0, wr_din}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    strobes.delete();
    push(8'h50, 8'h22);
    wait_idle(50);
    chk("t5_count", strobes.size(), 2);
    if (strobes.size() == 2) begin
      chk("t5_addr_again", {23'b0, strobes[0].a0, strobes[0].din}, 32'h050);
      chk("t5_data", {23'b0, strobes[1].a0, strobes[1].din}, 32'h122);
    end
    addr_cache_en = 1'b0;
    strobes.delete();

    // Push and pop together at level 1, then wrap over 20 commands
    push(8'h60, 8'h00);
    wait_strobe(20);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 8'h61; cmd_data = 8'h01;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t6_level_same", {28'b0, level}, 1);
    chk("t6_data_strobe", {22'b0, wr_write, wr_a0, wr_din}, 32'h300);
    for (int i = 2; i < 20; i++) push(8'h60 + 8'(i), 8'(i));
    wait_idle(2000);
    chk("t6_count", strobes.size(), 40);
    if (strobes.size() == 40) begin
      for (int i = 0; i < 20; i++) begin
        chk("t6_addr", {23'b0, strobes[2*i].a0, strobes[2*i].din}, 32'h060 + i);
        chk("t6_data", {23'b0, strobes[2*i+1].a0, strobes[2*i+1].din}, 32'h100 + i);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
